// File: rtl/conversor_serial_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel frame receiver:
// FSM encoding, frame-bit levels and a counter-width helper.
package conversor_serial_paralelo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Index width for a WIDTH-entry word; a 1-bit word still needs a 1-bit index.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/registrador_deslocamento.sv
// WIDTH-bit addressed shift register: each enabled cycle writes the serial
// bit into the position selected by idx, so q[0] holds the first bit received.
module registrador_deslocamento
  import conversor_serial_paralelo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        en,
  input  logic [idx_width(WIDTH)-1:0] idx,
  input  logic                        din,
  output logic [0:WIDTH-1]            q
);

  // NOTE: the word is cleared on reset so the register never exposes stale
  // bits from an aborted frame; it is small enough that this costs little.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q[idx] <= din;
    end
  end

endmodule

// File: rtl/conversor_serial_paralelo.sv
// Frame receiver: start bit, WIDTH data bits, optional parity, stop bit.
// Good frames update d with a one-cycle load; malformed frames pulse err.
module conversor_serial_paralelo
  import conversor_serial_paralelo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rx,
  input  logic             rx_en,
  output logic [0:WIDTH-1] d,
  output logic             load,
  output logic             err,
  output logic             busy
);

  localparam int                IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             par_acc, par_acc_nxt;
  logic             par_err, par_err_nxt;
  logic             shift_en;
  logic [0:WIDTH-1] shift_q;
  logic             frame_good, frame_bad;

  registrador_deslocamento #(.WIDTH(WIDTH)) u_shift (
    .clk (clk),
    .clr (clr),
    .en  (shift_en),
    .idx (cnt),
    .din (rx),
    .q   (shift_q)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and the process order cannot change behaviour.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      par_acc <= 1'b0;
      par_err <= 1'b0;
      d       <= '0;
      load    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      par_acc <= par_acc_nxt;
      par_err <= par_err_nxt;
      load    <= frame_good;
      err     <= frame_bad;
      if (frame_good) begin
        d <= shift_q;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    par_acc_nxt = par_acc;
    par_err_nxt = par_err;
    shift_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_en && rx == START_BIT) begin
          state_nxt   = DATA;
          cnt_nxt     = '0;
          par_acc_nxt = 1'b0;
          par_err_nxt = 1'b0;
        end
      end
      DATA: begin
        if (rx_en) begin
          shift_en    = 1'b1;
          par_acc_nxt = par_acc ^ rx;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            cnt_nxt = cnt + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        // XOR of data plus parity must equal 0 for even, 1 for odd.
        if (rx_en) begin
          par_err_nxt = ((par_acc ^ rx) != PARITY_ODD);
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (rx_en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_good = (state == STOP) && rx_en && (rx == STOP_BIT) && !par_err;
    frame_bad  = (state == STOP) && rx_en && !((rx == STOP_BIT) && !par_err);
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_conversor_serial_paralelo.sv
// Directed bench for conversor_serial_paralelo (WIDTH=8, even parity).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_conversor_serial_paralelo;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rx = 1'b0;
  logic       rx_en = 1'b1;
  logic [0:7] d;
  logic       load, err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;
  int err_cnt  = 0;
  int load_base, err_base;

  conversor_serial_paralelo #(.WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk   (clk),
    .clr   (clr),
    .rx    (rx),
    .rx_en (rx_en),
    .d     (d),
    .load  (load),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters read the pre-edge value of the registered outputs.
  always @(posedge clk) begin
    if (load) load_cnt <= load_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [0:7] obs, input logic [0:7] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic b);
    rx_en = en;
    rx    = b;
    @(negedge clk);
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  // Start strobe first (no gap, so it can land in a load cycle), then gapped bits.
  task automatic send_frame(input logic [0:7] data, input logic par_bit,
                            input logic stop_bit, input int max_gap);
    step(1'b1, 1'b0);
    check_bit("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      gap(max_gap);
      step(1'b1, data[i]);
    end
    gap(max_gap);
    step(1'b1, par_bit);
    gap(max_gap);
    step(1'b1, stop_bit);
  endtask

  task automatic mark();
    load_base = load_cnt;
    err_base  = err_cnt;
  endtask

  initial begin
    // Reset for two edges while a start bit is presented; clr must win.
    @(negedge clk);
    @(negedge clk);
    check_word("reset_d", d, 8'h00);
    check_bit("reset_load", load, 1'b0);
    check_bit("reset_err", err, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    clr   = 1'b0;
    rx_en = 1'b0;
    rx    = 1'b1;
    @(negedge clk);

    // Good frame: data 1,0,1,1,0,0,1,0 has four ones, even parity bit 0.
    mark();
    send_frame(8'b1011_0010, 1'b0, 1'b1, 0);
    check_bit("good_load", load, 1'b1);
    check_bit("good_err", err, 1'b0);
    check_word("good_d", d, 8'b1011_0010);
    check_bit("good_busy_low", busy, 1'b0);
    step(1'b0, 1'b1);
    check_bit("good_load_one_cycle", load, 1'b0);
    check_int("good_load_count", load_cnt - load_base, 1);
    check_int("good_err_count", err_cnt - err_base, 0);

    // Parity error: same data, parity bit 1.
    mark();
    send_frame(8'b1011_0010, 1'b1, 1'b1, 0);
    check_bit("parity_err", err, 1'b1);
    check_bit("parity_load", load, 1'b0);
    check_word("parity_d_kept", d, 8'b1011_0010);
    step(1'b0, 1'b1);
    check_bit("parity_err_one_cycle", err, 1'b0);
    check_int("parity_err_count", err_cnt - err_base, 1);
    check_int("parity_load_count", load_cnt - load_base, 0);

    // Framing error: good data and parity, stop bit 0.
    mark();
    send_frame(8'b0111_0001, 1'b0, 1'b0, 0);
    check_bit("frame_err", err, 1'b1);
    check_bit("frame_load", load, 1'b0);
    check_bit("frame_idle", busy, 1'b0);
    check_word("frame_d_kept", d, 8'b1011_0010);
    step(1'b0, 1'b1);
    check_int("frame_err_count", err_cnt - err_base, 1);
    check_int("frame_load_count", load_cnt - load_base, 0);

    // Gapped strobes, second frame's start bit strobed in the load cycle.
    mark();
    send_frame(8'b0111_0001, 1'b0, 1'b1, 3);
    check_bit("gap1_load", load, 1'b1);
    check_word("gap1_d", d, 8'b0111_0001);
    send_frame(8'b1100_1011, 1'b1, 1'b1, 3);
    check_bit("gap2_load", load, 1'b1);
    check_bit("gap2_err", err, 1'b0);
    check_word("gap2_d", d, 8'b1100_1011);
    step(1'b0, 1'b1);
    check_int("gap_load_count", load_cnt - load_base, 2);
    check_int("gap_err_count", err_cnt - err_base, 0);

    // Reset after four data bits, then a complete good frame.
    mark();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    clr = 1'b1;
    step(1'b1, 1'b0);
    clr = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_word("abort_d", d, 8'h00);
    step(1'b0, 1'b1);
    send_frame(8'b0001_1110, 1'b0, 1'b1, 0);
    check_bit("after_abort_load", load, 1'b1);
    check_word("after_abort_d", d, 8'b0001_1110);
    step(1'b0, 1'b1);
    check_int("abort_load_count", load_cnt - load_base, 1);
    check_int("abort_err_count", err_cnt - err_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
